// File: rtl/beep_arbiter.sv
// beep_arbiter: shares one passive buzzer between keypress, result and error
// requesters. Strobes are queued in a sticky pending register, granted by
// fixed priority (bit 2 highest), and each grant plays a pulse-train pattern
// of 500 Hz tone bursts separated by silent gaps.
`timescale 1ns/1ps
module beep_arbiter #(
    parameter int ON_MS      = 100,
    parameter int OFF_MS     = 60,
    parameter int KEY_PULSES = 1,
    parameter int RES_PULSES = 2,
    parameter int ERR_PULSES = 3,
    parameter int CNT_W      = 8
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       busy,
    output logic       beep
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    // A configured pulse count of 0 still plays one pulse; counts are 4-bit.
    function automatic logic [3:0] pulse_cnt(input int n);
        return (n < 1) ? 4'd1 : 4'(n);
    endfunction

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_MS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_MS - 1);
    localparam logic [3:0]       KEY_P    = pulse_cnt(KEY_PULSES);
    localparam logic [3:0]       RES_P    = pulse_cnt(RES_PULSES);
    localparam logic [3:0]       ERR_P    = pulse_cnt(ERR_PULSES);

    state_t           state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       grant_q, grant_d;
    logic             beep_q, beep_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [3:0]       pulses_q, pulses_d;

    logic [2:0]       pending_clr;
    logic [2:0]       hi_mask;
    logic             preempt;

    // Requesters strictly above the current grant; only these may abort it.
    always_comb begin
        hi_mask = {grant_q[1] | grant_q[0], grant_q[0], 1'b0};
        preempt = |(pending_q & hi_mask);
    end

    // Next-state, pattern sequencing and request queue update.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beep_d      = beep_q;
        phase_d     = phase_q;
        pulses_d    = pulses_q;
        pending_clr = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_ON;
                    beep_d  = 1'b0;
                    phase_d = '0;
                    if (pending_q[2]) begin
                        grant_d  = 3'b100;
                        pulses_d = ERR_P;
                    end else if (pending_q[1]) begin
                        grant_d  = 3'b010;
                        pulses_d = RES_P;
                    end else begin
                        grant_d  = 3'b001;
                        pulses_d = KEY_P;
                    end
                    pending_clr = grant_d;
                end
            end
            S_ON: begin
                if (preempt) begin
                    // Aborted pattern is dropped; arbitration happens next tick.
                    state_d = S_IDLE;
                    grant_d = 3'b000;
                    beep_d  = 1'b1;
                    phase_d = '0;
                end else if (phase_q == ON_LAST) begin
                    beep_d  = 1'b1;
                    phase_d = '0;
                    if (pulses_q > 4'd1) begin
                        pulses_d = pulses_q - 4'd1;
                        state_d  = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 3'b000;
                    end
                end else begin
                    beep_d  = ~beep_q;
                    phase_d = phase_q + 1'b1;
                end
            end
            S_GAP: begin
                if (preempt) begin
                    state_d = S_IDLE;
                    grant_d = 3'b000;
                    beep_d  = 1'b1;
                    phase_d = '0;
                end else if (phase_q == OFF_LAST) begin
                    state_d = S_ON;
                    beep_d  = 1'b0;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                beep_d  = 1'b1;
                phase_d = '0;
            end
        endcase

        // A new strobe beats the clear of the same bit, so it replays later.
        pending_d = (pending_q & ~pending_clr) | req;
    end

    // State and datapath registers; reset gives a silent, idle buzzer.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 3'b000;
            grant_q   <= 3'b000;
            beep_q    <= 1'b1;
            phase_q   <= '0;
            pulses_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            beep_q    <= beep_d;
            phase_q   <= phase_d;
            pulses_q  <= pulses_d;
        end
    end

    assign grant = grant_q;
    assign beep  = beep_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_beep_arbiter.sv
// Directed bench for beep_arbiter with default parameters.
`timescale 1ns/1ps
module tb_beep_arbiter;

    localparam int ON  = 100;
    localparam int OFF = 60;

    logic       clk_1khz;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] grant;
    logic       busy;
    logic       beep;

    int total = 0;
    int bad   = 0;

    beep_arbiter dut (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .busy     (busy),
        .beep     (beep)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic expect_out(input string tag, input int g, input int bz, input int bp);
        chk({tag, ".grant"}, int'(grant), g);
        chk({tag, ".busy"},  int'(busy),  bz);
        chk({tag, ".beep"},  int'(beep),  bp);
    endtask

    task automatic idle_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            expect_out(tag, 0, 0, 1);
        end
    endtask

    function automatic int plen(input int p);
        return p * ON + (p - 1) * OFF;
    endfunction

    // Checks n ticks of a pattern starting at pattern offset off0.
    // Offset 0 is the grant edge; tone starts at beep=0 and toggles.
    task automatic run_seg(input string tag, input int g, input int off0, input int n);
        int off, ph;
        for (int i = 0; i < n; i++) begin
            step();
            off = off0 + i;
            ph  = off % (ON + OFF);
            if (ph < ON) expect_out(tag, g, 1, ph % 2);
            else         expect_out(tag, g, 1, 1);
        end
    endtask

    task automatic strobe(input logic [2:0] r);
        req = r;
        step();
        req = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;

        // Reset held three ticks, then quiet idle.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("rst_hold", 0, 0, 1);
        end
        rst_n = 1'b1;
        idle_ticks("rst_idle", 50);

        // Single keypress strobed at edge 10.
        idle_ticks("key_pre", 9);
        strobe(3'b001);
        expect_out("key_strobe_edge", 0, 0, 1);
        run_seg("key", 1, 0, plen(1));
        idle_ticks("key_end", 5);

        // Error pattern: three pulses with gaps.
        strobe(3'b100);
        expect_out("err_strobe_edge", 0, 0, 1);
        run_seg("err", 4, 0, plen(3));
        idle_ticks("err_end", 5);

        // Simultaneous result + keypress: result first, one idle tick, keypress.
        strobe(3'b011);
        run_seg("sim_res", 2, 0, plen(2));
        idle_ticks("sim_gap", 1);
        run_seg("sim_key", 1, 0, plen(1));
        idle_ticks("sim_end", 5);

        // Preemption: keypress at edge 0, error strobe at edge 40.
        strobe(3'b001);
        run_seg("pre_key", 1, 0, 39);
        strobe(3'b100);
        expect_out("pre_strobe_edge", 1, 1, 39 % 2);
        idle_ticks("pre_idle", 1);
        run_seg("pre_err", 4, 0, plen(3));
        idle_ticks("pre_no_replay", 20);

        // Clear-vs-set collision: strobe held across the arbitration edge.
        req = 3'b010;
        step();
        step();
        req = 3'b000;
        run_seg("col_res1", 2, 1, plen(2) - 1);
        idle_ticks("col_gap", 1);
        run_seg("col_res2", 2, 0, plen(2));
        idle_ticks("col_end", 5);

        // Repeated lower-priority strobes collapse to a single keypress.
        strobe(3'b100);
        run_seg("dup_err_a", 4, 0, 4);
        strobe(3'b001);
        run_seg("dup_err_b", 4, 5, 1);
        strobe(3'b001);
        run_seg("dup_err_c", 4, 7, plen(3) - 7);
        idle_ticks("dup_gap", 1);
        run_seg("dup_key", 1, 0, plen(1));
        idle_ticks("dup_once", 20);

        // Asynchronous reset in the middle of a tone.
        strobe(3'b100);
        run_seg("mrst_err", 4, 0, 51);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("mrst_async", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("mrst_hold", 0, 0, 1);
        end
        rst_n = 1'b1;
        idle_ticks("mrst_after", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beep_arbiter.md
# beep_arbiter

Shares the single passive buzzer between three sound requesters: keypress click, result chime and error alarm. It runs on the 1 kHz system tick and queues one-cycle request strobes. It grants the buzzer by fixed priority and generates a pulse-train pattern per requester, toggling `beep` every tick while a tone is on (500 Hz square wave). It sits between the calculator control FSM and the buzzer pin, and replaces direct buzzer drive by individual modules.

## Interface
- `ON_MS`, default 100: tone-on length per pulse, in ticks (≥2).
- `OFF_MS`, default 60: silent gap between pulses, in ticks (≥1).
- `KEY_PULSES`, default 1: pulse count for requester 0 (keypress).
- `RES_PULSES`, default 2: pulse count for requester 1 (result).
- `ERR_PULSES`, default 3: pulse count for requester 2 (error).
- `CNT_W`, default 8: phase counter width; must hold max(ON_MS, OFF_MS)−1.
- `clk_1khz`, in, 1: 1 kHz clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 3: one-tick request strobes. Bit 2 has the highest priority.
- `grant`, out, 3: one-hot, identifies the requester whose pattern is playing. All zeros when idle.
- `busy`, out, 1: high in ON or GAP.
- `beep`, out, 1: buzzer drive. Idle level is 1.

## Operation
- **Reset values:** `pending`=000, state=IDLE, `grant`=000, `busy`=0, `beep`=1, phase counter 0, pulse counter 0.
- **Request capture:** `pending[i]` is set on any edge where `req[i]`=1. Strobes are sticky, and repeated strobes for a class already pending collapse to one.
- **Clear-vs-set collision:** the clear of a granted bit and a new strobe for the same bit can land on the same edge. The set wins, and the pattern replays afterwards.
- **States:** IDLE, ON, GAP.
- **IDLE:**
  - If `pending` is nonzero, select the highest set index k.
  - Clear `pending[k]`, set `grant`=onehot(k), load the pulse counter with that class's pulse count, zero the phase counter, and go to ON.
  - `beep` goes to 0 on that same edge.
- **ON:**
  - `beep` toggles every edge.
  - When the phase counter reaches ON_MS−1: if pulses left > 1, decrement and go to GAP. Otherwise go to IDLE with `grant`=000.
  - In both cases `beep` is forced to 1 and the phase counter is zeroed.
- **GAP:**
  - `beep` holds at 1.
  - When the phase counter reaches OFF_MS−1, go to ON. `beep` goes to 0 and the phase counter is zeroed.
- **Preemption:** in ON or GAP, a `pending` bit with index greater than the current grant aborts the current pattern on the next edge.
  - The aborted pattern is dropped, not re-queued.
  - On that edge: state goes to IDLE, `grant`=000, `beep`=1.
  - Arbitration follows on the edge after.
- **No preemption:** equal- or lower-priority pending bits never preempt. They wait for IDLE.
- **Counter rules:** the phase counter is unsigned CNT_W bits and never wraps in legal configurations. The pulse counter is 4 bits. A pulse count of 0 is treated as 1.
- **Mid-pattern reset:** `rst_n` low in the middle of a pattern immediately (asynchronously) forces all reset values, including `beep`=1. Pending requests are lost.

## Timing
- Strobe at edge N sets `pending` at N. Grant, `busy`=1 and the first `beep`=0 appear at edge N+1. Request-to-sound latency is 1 tick.
- Each ON phase is exactly ON_MS ticks and each GAP exactly OFF_MS ticks.
- Total pattern length = P·ON_MS + (P−1)·OFF_MS ticks. `busy` falls at the edge ending the last ON.
- Back-to-back patterns: one IDLE tick (`beep`=1, `grant`=000) separates consecutive patterns.
- A preempting strobe at edge M produces IDLE at M+1 and the new grant at M+2.
- Outputs are registered. No combinational path exists from `req` to any output.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 ticks, then release with no requests. Expect `beep`=1, `grant`=000, `busy`=0 for 50 ticks.
- **Single keypress (defaults):** `req`=001 at edge 10.
  - Edge 11: `grant`=001, `beep`=0.
  - Edges 11–110: `beep` alternates each tick.
  - Edge 111: IDLE, `beep`=1, `busy`=0.
- **Error pattern:** `req`=100 at edge 0. Expect ON 1–100, GAP 101–160, ON 161–260, GAP 261–320, ON 321–420, IDLE at edge 421, `grant`=100 throughout.
- **Simultaneous strobes:** `req`=011 at edge 0.
  - Result plays first: edges 1–260, IDLE at 261.
  - Keypress granted at edge 262 and plays 262–361.
- **Preemption:** keypress at edge 0, error strobe at edge 40.
  - Edge 41: IDLE, `beep`=1.
  - Edge 42: `grant`=100, and the full 3-pulse pattern follows.
  - Keypress is not replayed afterwards.
- **Reset mid-tone:** drop `rst_n` at tick 50 of an error pattern. Expect `beep`=1 and `grant`=000 immediately, and no pattern resumes after release.
